// File: rtl/reaction_meter_pkg.sv
// Shared constants for the reaction meter: state encoding, LFSR seed/taps,
// default prescaler division and the LFSR step function.
package reaction_meter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_ARMED = 2'd2
  } state_e;

  localparam int unsigned DEF_TICK_DIV = 100_000;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Taps 16,14,13,11 expressed as bit positions 15,13,12,10.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // One Fibonacci step: shift left, feed back the XOR of the tapped bits.
  // A non-zero state never maps to zero with these maximal-length taps.
  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    return {cur[14:0], ^(cur & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/reaction_meter_ms_tick_gen.sv
// Millisecond prescaler: counts 0..TICK_DIV-1 and flags the last count.
// clr restarts the count so the first tick lands TICK_DIV cycles later.
module ms_tick_gen
  import reaction_meter_pkg::*;
#(
  parameter int unsigned TICK_DIV = DEF_TICK_DIV
) (
  input  logic ck,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tick = (cnt_q == LAST);

  // Next count: clear wins, otherwise wrap at the last value.
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clr || tick) begin
      cnt_d = '0;
    end
  end

  // Prescaler register.
  always_ff @(posedge ck or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/reaction_meter.sv
// Reaction meter: random pre-delay, stimulus LED, millisecond measurement
// of the response with false-start and timeout detection.
module reaction_meter
  import reaction_meter_pkg::*;
#(
  parameter int unsigned TICK_DIV     = DEF_TICK_DIV,
  parameter int unsigned MAX_MS       = 5000,
  parameter int unsigned MIN_DELAY_MS = 1000,
  parameter int unsigned DELAY_MASK   = 2047,
  parameter int unsigned RES_W        = 13
) (
  input  logic             ck,
  input  logic             reset,
  input  logic             start,
  input  logic             resp,
  output logic             led,
  output logic             busy,
  output logic [RES_W-1:0] result_ms,
  output logic             valid,
  output logic             timeout,
  output logic             early
);

  // MIN_DELAY_MS + DELAY_MASK and MAX_MS are assumed to fit in RES_W bits;
  // the target sum below is deliberately not wrapped or saturated.
  localparam logic [RES_W-1:0] MAX_V   = RES_W'(MAX_MS);
  localparam logic [RES_W-1:0] MAX_M1  = RES_W'(MAX_MS - 1);
  localparam logic [RES_W-1:0] MIN_V   = RES_W'(MIN_DELAY_MS);
  localparam logic [15:0]      MASK_V  = 16'(DELAY_MASK);

  state_e           state_q, state_d;
  logic [15:0]      lfsr_q;
  logic [RES_W-1:0] ms_cnt_q, ms_cnt_d;
  logic [RES_W-1:0] target_q, target_d;
  logic [RES_W-1:0] result_q, result_d;
  logic             led_q, led_d;
  logic             busy_q, busy_d;
  logic             valid_q, valid_d;
  logic             timeout_q, timeout_d;
  logic             early_q, early_d;
  logic             tick;
  logic             clr;

  // Restart the prescaler on every state change so each state gets full
  // millisecond periods from its entry edge.
  assign clr = (state_d != state_q);

  ms_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .ck    (ck),
    .reset (reset),
    .clr   (clr),
    .tick  (tick)
  );

  // Next-state, counter and output decode; resp takes priority over tick.
  always_comb begin
    state_d   = state_q;
    ms_cnt_d  = ms_cnt_q;
    target_d  = target_q;
    result_d  = result_q;
    valid_d   = 1'b0;
    timeout_d = 1'b0;
    early_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_DELAY;
          target_d = MIN_V + RES_W'(lfsr_q & MASK_V);
          ms_cnt_d = '0;
        end
      end
      ST_DELAY: begin
        if (resp) begin
          state_d = ST_IDLE;
          early_d = 1'b1;
        end else if (tick) begin
          if (ms_cnt_q == target_q - RES_W'(1)) begin
            state_d  = ST_ARMED;
            ms_cnt_d = '0;
          end else begin
            ms_cnt_d = ms_cnt_q + RES_W'(1);
          end
        end
      end
      ST_ARMED: begin
        if (resp) begin
          state_d  = ST_IDLE;
          result_d = ms_cnt_q;
          valid_d  = 1'b1;
        end else if (tick) begin
          if (ms_cnt_q == MAX_M1) begin
            state_d   = ST_IDLE;
            result_d  = MAX_V;
            timeout_d = 1'b1;
          end else begin
            ms_cnt_d = ms_cnt_q + RES_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    led_d  = (state_d == ST_ARMED);
    busy_d = (state_d != ST_IDLE);
  end

  // State, counters, LFSR and registered outputs.
  always_ff @(posedge ck or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      lfsr_q    <= LFSR_SEED;
      ms_cnt_q  <= '0;
      target_q  <= '0;
      result_q  <= '0;
      led_q     <= 1'b0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      early_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_next(lfsr_q);
      ms_cnt_q  <= ms_cnt_d;
      target_q  <= target_d;
      result_q  <= result_d;
      led_q     <= led_d;
      busy_q    <= busy_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
      early_q   <= early_d;
    end
  end

  assign led       = led_q;
  assign busy      = busy_q;
  assign result_ms = result_q;
  assign valid     = valid_q;
  assign timeout   = timeout_q;
  assign early     = early_q;

endmodule

// File: tb/tb_reaction_meter.sv
// Directed bench for reaction_meter with a 4-cycle millisecond, 3 ms fixed
// delay and a 10 ms timeout.
module tb_reaction_meter;

  localparam int unsigned TICK_DIV     = 4;
  localparam int unsigned MAX_MS       = 10;
  localparam int unsigned MIN_DELAY_MS = 3;
  localparam int unsigned DELAY_MASK   = 0;
  localparam int unsigned RES_W        = 13;

  logic             ck = 1'b0;
  logic             reset;
  logic             start;
  logic             resp;
  logic             led;
  logic             busy;
  logic [RES_W-1:0] result_ms;
  logic             valid;
  logic             timeout;
  logic             early;

  int tests_run = 0;
  int tests_failed = 0;

  reaction_meter #(
    .TICK_DIV     (TICK_DIV),
    .MAX_MS       (MAX_MS),
    .MIN_DELAY_MS (MIN_DELAY_MS),
    .DELAY_MASK   (DELAY_MASK),
    .RES_W        (RES_W)
  ) dut (
    .ck        (ck),
    .reset     (reset),
    .start     (start),
    .resp      (resp),
    .led       (led),
    .busy      (busy),
    .result_ms (result_ms),
    .valid     (valid),
    .timeout   (timeout),
    .early     (early)
  );

  always #5 ck = ~ck;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge ck);
    #1;
  endtask

  logic [31:0] acc;
  int          cnt;
  logic        led_seen;

  initial begin
    reset = 1'b0;
    start = 1'b0;
    resp  = 1'b0;

    // 1: reset with start pulsed, then idle quietly
    step();
    start = 1'b1;
    step();
    step();
    chk("rst_led", led, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pulses", {valid, timeout, early}, 0);
    chk("rst_result", result_ms, 0);
    start = 1'b0;
    reset = 1'b1;
    acc = '0;
    for (int i = 0; i < 100; i++) begin
      step();
      acc = acc | {led, busy, valid, timeout, early} | 32'(result_ms);
    end
    chk("idle_quiet", acc, 0);

    // 2: normal measurement, resp on the 12th edge after ARMED entry
    start = 1'b1;
    step();
    start = 1'b0;
    chk("t2_busy", busy, 1);
    chk("t2_led_delay", led, 0);
    for (int i = 0; i < 11; i++) step();
    chk("t2_led_before_armed", led, 0);
    step();
    chk("t2_led_armed", led, 1);
    for (int i = 0; i < 11; i++) step();
    chk("t2_led_still", led, 1);
    resp = 1'b1;
    step();
    resp = 1'b0;
    chk("t2_valid", valid, 1);
    chk("t2_result", result_ms, 2);
    chk("t2_led_off", led, 0);
    chk("t2_busy_off", busy, 0);
    chk("t2_no_to", timeout, 0);
    step();
    chk("t2_valid_one", valid, 0);

    // 3: false start 5 cycles after start
    start = 1'b1;
    step();
    start = 1'b0;
    led_seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      led_seen = led_seen | led;
    end
    chk("t3_no_early_yet", early, 0);
    resp = 1'b1;
    step();
    resp = 1'b0;
    led_seen = led_seen | led;
    chk("t3_early", early, 1);
    chk("t3_busy", busy, 0);
    chk("t3_valid", valid, 0);
    chk("t3_result_kept", result_ms, 2);
    step();
    led_seen = led_seen | led;
    chk("t3_early_one", early, 0);
    chk("t3_led_never", led_seen, 0);

    // 4: no response, timeout after 40 lit cycles
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 12; i++) step();
    chk("t4_armed", led, 1);
    cnt = 1;
    for (int i = 0; i < 100; i++) begin
      step();
      if (!led) break;
      cnt++;
    end
    chk("t4_led_len", cnt, 40);
    chk("t4_timeout", timeout, 1);
    chk("t4_result", result_ms, 10);
    chk("t4_no_valid", valid, 0);
    chk("t4_busy_off", busy, 0);
    step();
    chk("t4_timeout_one", timeout, 0);

    // 5: resp on the final tick wins, extra start in ARMED ignored
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 12; i++) step();
    chk("t5_armed", led, 1);
    for (int i = 0; i < 5; i++) step();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 33; i++) step();
    chk("t5_led_before_final", led, 1);
    resp = 1'b1;
    step();
    resp = 1'b0;
    chk("t5_valid", valid, 1);
    chk("t5_result", result_ms, 9);
    chk("t5_no_timeout", timeout, 0);
    chk("t5_led_off", led, 0);
    step();
    chk("t5_after", {valid, timeout, early}, 0);

    // 6: asynchronous reset in the middle of ARMED
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 17; i++) step();
    chk("t6_armed", led, 1);
    #2;
    reset = 1'b0;
    #1;
    chk("t6_led_async", led, 0);
    chk("t6_busy_async", busy, 0);
    chk("t6_result_async", result_ms, 0);
    acc = '0;
    resp = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      acc = acc | {valid, timeout, early};
    end
    resp = 1'b0;
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      acc = acc | {valid, timeout, early, led, busy};
    end
    chk("t6_no_pulses", acc, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
